seq_detector_param: RTL and testbench



---
 rtl/seq_detector_param_if.sv | 25 ++
 rtl/seq_detector_param.sv | 66 ++++++
 tb/tb_seq_detector_param.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_detector_param_if.sv
// Bus bundle for seq_detector_param: symbol stream, pattern and match status.
// The master drives symbols and the pattern; the slave (detector) returns the status.
interface seq_detector_param_if #(
  parameter int W     = 1,
  parameter int N     = 3,
  parameter int CNT_W = 4
);
  logic                      clear;
  logic                      in_valid;
  logic [W-1:0]              sym;
  logic [N*W-1:0]            pattern;
  logic                      q;
  logic [CNT_W-1:0]          match_cnt;
  logic [$clog2(N+1)-1:0]    state_var;

  modport master (
    output clear, in_valid, sym, pattern,
    input  q, match_cnt, state_var
  );

  modport slave (
    input  clear, in_valid, sym, pattern,
    output q, match_cnt, state_var
  );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised Moore sequence detector: N-symbol history compared against a runtime
// pattern. It produces a registered match pulse, a saturating match count and the fill level.
module seq_detector_param #(
  parameter int W       = 1,
  parameter int N       = 3,
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  seq_detector_param_if.slave bus
);

  localparam int FW = $clog2(N+1);

  // Only the endpoints of the fill counter are named; intermediate levels are plain counts.
  typedef enum logic [FW-1:0] {
    FILL_0 = '0,
    FILL_N = FW'(N)
  } fill_e;

  fill_e              fill;
  fill_e              fill_next;
  logic [N*W-1:0]     hist;
  logic [N*W-1:0]     hist_next;
  logic               hit;
  logic               q_r;
  logic [CNT_W-1:0]   cnt_r;

  // hist[W*0 +: W] holds the oldest symbol, so the shifted history lines up with pattern.
  always_comb begin
    hist_next = {bus.sym, hist[N*W-1:W]};
    fill_next = (fill == FILL_N) ? FILL_N : fill_e'(fill + 1'b1);
    hit       = (fill_next == FILL_N) && (hist_next == bus.pattern);
  end

  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      hist  <= '0;
      fill  <= FILL_0;
      q_r   <= 1'b0;
      cnt_r <= '0;
    end else if (fill > FILL_N) begin
      fill <= FILL_0;
      q_r  <= 1'b0;
    end else if (bus.in_valid) begin
      hist <= hist_next;
      q_r  <= hit;
      if (hit && (cnt_r != '1)) begin
        cnt_r <= cnt_r + 1'b1;
      end
      if (hit && (OVERLAP == 0)) begin
        fill <= FILL_0;
      end else begin
        fill <= fill_next;
      end
    end else begin
      q_r <= 1'b0;
    end
  end

  assign bus.q         = q_r;
  assign bus.match_cnt = cnt_r;
  assign bus.state_var = fill;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: four configurations share one stimulus stream,
// each tracked by a queue-based reference model of the accepted-symbol history.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset, clear, in_valid;
  logic       sym1;
  logic [1:0] sym2;
  logic [2:0] pattern3;
  logic [1:0] pattern2;
  logic [7:0] pattern4;

  int unsigned tests_run = 0;
  int unsigned failures  = 0;

  always #5 clk = ~clk;

  // a: W1 N3 overlap, b: W1 N3 non-overlap, c: W1 N2 CNT_W2 overlap, d: W2 N4 non-overlap
  seq_detector_param_if #(.W(1), .N(3), .CNT_W(4)) if_a ();
  seq_detector_param_if #(.W(1), .N(3), .CNT_W(4)) if_b ();
  seq_detector_param_if #(.W(1), .N(2), .CNT_W(2)) if_c ();
  seq_detector_param_if #(.W(2), .N(4), .CNT_W(3)) if_d ();

  seq_detector_param #(.W(1), .N(3), .OVERLAP(1), .CNT_W(4)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  seq_detector_param #(.W(1), .N(3), .OVERLAP(0), .CNT_W(4)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
  seq_detector_param #(.W(1), .N(2), .OVERLAP(1), .CNT_W(2)) dut_c (.clk(clk), .reset(reset), .bus(if_c));
  seq_detector_param #(.W(2), .N(4), .OVERLAP(0), .CNT_W(3)) dut_d (.clk(clk), .reset(reset), .bus(if_d));

  assign if_a.clear = clear; assign if_a.in_valid = in_valid; assign if_a.sym = sym1; assign if_a.pattern = pattern3;
  assign if_b.clear = clear; assign if_b.in_valid = in_valid; assign if_b.sym = sym1; assign if_b.pattern = pattern3;
  assign if_c.clear = clear; assign if_c.in_valid = in_valid; assign if_c.sym = sym1; assign if_c.pattern = pattern2;
  assign if_d.clear = clear; assign if_d.in_valid = in_valid; assign if_d.sym = sym2; assign if_d.pattern = pattern4;

  int unsigned ha[$], hb[$], hc[$], hd[$];
  int unsigned ca = 0, cb = 0, cc = 0, cd = 0;
  bit          ea = 0, eb = 0, ec = 0, ed = 0;

  // Reference: keep the last accepted symbols; a match is the newest n equal to the pattern.
  task automatic mstep(inout int unsigned h[$], inout int unsigned cnt, output bit qx,
                       input int unsigned n, input int unsigned w, input int unsigned ov,
                       input int unsigned cmax, input logic [31:0] pat, input logic [31:0] s);
    bit          m;
    logic [31:0] mask;
    qx   = 1'b0;
    mask = (32'd1 << w) - 32'd1;
    if (reset || clear) begin
      h.delete();
      cnt = 0;
    end else if (in_valid) begin
      h.push_back(s);
      if (h.size() > n) void'(h.pop_front());
      if (h.size() == n) begin
        m = 1'b1;
        for (int unsigned i = 0; i < n; i++)
          if (h[i] != ((pat >> (w * i)) & mask)) m = 1'b0;
        if (m) begin
          qx = 1'b1;
          if (cnt < cmax) cnt++;
          if (ov == 0) h.delete();
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    mstep(ha, ca, ea, 3, 1, 1, 15, 32'(pattern3), 32'(sym1));
    mstep(hb, cb, eb, 3, 1, 0, 15, 32'(pattern3), 32'(sym1));
    mstep(hc, cc, ec, 2, 1, 1, 3,  32'(pattern2), 32'(sym1));
    mstep(hd, cd, ed, 4, 2, 0, 7,  32'(pattern4), 32'(sym2));
    #1;
  endtask

  task automatic drive(input bit r, input bit c, input bit v, input bit s);
    reset    = r;
    clear    = c;
    in_valid = v;
    sym1     = s;
    sym2     = 2'($urandom_range(0, 3));
  endtask

  task automatic test_reset();
    drive(1, 0, 1, 1);
    cycle();
    cycle();
    if (if_a.q !== 1'b0) begin failures++; $display("FAIL reset_q_a got %0b exp 0", if_a.q); end
    tests_run++;
    if (if_a.match_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt_a got %0d exp 0", if_a.match_cnt); end
    tests_run++;
    if (if_a.state_var !== 2'd0) begin failures++; $display("FAIL reset_state_a got %0d exp 0", if_a.state_var); end
    tests_run++;
    if (if_b.state_var !== 2'd0) begin failures++; $display("FAIL reset_state_b got %0d exp 0", if_b.state_var); end
    tests_run++;
    if (if_c.match_cnt !== 2'd0) begin failures++; $display("FAIL reset_cnt_c got %0d exp 0", if_c.match_cnt); end
    tests_run++;
    if (if_d.state_var !== 3'd0 || if_d.q !== 1'b0)
      begin failures++; $display("FAIL reset_d got state %0d q %0b exp 0 0", if_d.state_var, if_d.q); end
    tests_run++;
  endtask

  task automatic test_overlap_modes();
    bit sv[5]    = '{1, 0, 1, 0, 1};
    int qa_e[5]  = '{0, 0, 1, 0, 1};
    int sa_e[5]  = '{1, 2, 3, 3, 3};
    int qb_e[5]  = '{0, 0, 1, 0, 0};
    int sb_e[5]  = '{1, 2, 0, 1, 2};
    pattern3 = 3'b101;
    drive(0, 1, 0, 0);
    cycle();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 1, sv[k]);
      cycle();
      if (if_a.q !== 1'(qa_e[k])) begin failures++; $display("FAIL ovl_q_a sym%0d got %0b exp %0d", k+1, if_a.q, qa_e[k]); end
      tests_run++;
      if (if_a.state_var !== 2'(sa_e[k])) begin failures++; $display("FAIL ovl_state_a sym%0d got %0d exp %0d", k+1, if_a.state_var, sa_e[k]); end
      tests_run++;
      if (if_b.q !== 1'(qb_e[k])) begin failures++; $display("FAIL novl_q_b sym%0d got %0b exp %0d", k+1, if_b.q, qb_e[k]); end
      tests_run++;
      if (if_b.state_var !== 2'(sb_e[k])) begin failures++; $display("FAIL novl_state_b sym%0d got %0d exp %0d", k+1, if_b.state_var, sb_e[k]); end
      tests_run++;
    end
    if (if_a.match_cnt !== 4'd2) begin failures++; $display("FAIL ovl_cnt_a got %0d exp 2", if_a.match_cnt); end
    tests_run++;
    if (if_b.match_cnt !== 4'd1) begin failures++; $display("FAIL novl_cnt_b got %0d exp 1", if_b.match_cnt); end
    tests_run++;
  endtask

  task automatic test_valid_gap();
    bit vv[6]   = '{1, 1, 0, 0, 0, 1};
    bit sv[6]   = '{1, 1, 0, 0, 0, 0};
    int qe[6]   = '{0, 0, 0, 0, 0, 1};
    int se[6]   = '{1, 2, 2, 2, 2, 3};
    pattern3 = 3'b011;
    drive(0, 1, 0, 0);
    cycle();
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, vv[k], vv[k] ? sv[k] : 1'($urandom_range(0, 1)));
      cycle();
      if (if_a.q !== 1'(qe[k])) begin failures++; $display("FAIL gap_q_a step%0d got %0b exp %0d", k, if_a.q, qe[k]); end
      tests_run++;
      if (if_a.state_var !== 2'(se[k])) begin failures++; $display("FAIL gap_state_a step%0d got %0d exp %0d", k, if_a.state_var, se[k]); end
      tests_run++;
    end
    if (if_a.match_cnt !== 4'd1) begin failures++; $display("FAIL gap_cnt_a got %0d exp 1", if_a.match_cnt); end
    tests_run++;
  endtask

  task automatic test_reset_mid();
    bit rv[4] = '{0, 0, 1, 0};
    bit sv[4] = '{1, 0, 1, 1};
    pattern3 = 3'b101;
    drive(0, 1, 0, 0);
    cycle();
    for (int k = 0; k < 4; k++) begin
      drive(rv[k], 0, 1, sv[k]);
      cycle();
      if (if_a.q !== 1'b0) begin failures++; $display("FAIL rstmid_q_a step%0d got %0b exp 0", k, if_a.q); end
      tests_run++;
    end
    if (if_a.state_var !== 2'd1) begin failures++; $display("FAIL rstmid_state_a got %0d exp 1", if_a.state_var); end
    tests_run++;
    if (if_a.match_cnt !== 4'd0) begin failures++; $display("FAIL rstmid_cnt_a got %0d exp 0", if_a.match_cnt); end
    tests_run++;
  endtask

  task automatic test_back_to_back();
    int highs = 0;
    pattern2 = 2'b11;
    drive(0, 1, 0, 0);
    cycle();
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 1, 1);
      cycle();
      if (if_c.q === 1'b1) highs++;
      if (if_c.q !== (k > 0)) begin failures++; $display("FAIL b2b_q_c sym%0d got %0b exp %0b", k+1, if_c.q, (k > 0)); end
      tests_run++;
    end
    if (highs != 9) begin failures++; $display("FAIL b2b_highs_c got %0d exp 9", highs); end
    tests_run++;
    if (if_c.match_cnt !== 2'd3) begin failures++; $display("FAIL sat_cnt_c got %0d exp 3", if_c.match_cnt); end
    tests_run++;
    if (if_c.state_var !== 2'd2) begin failures++; $display("FAIL b2b_state_c got %0d exp 2", if_c.state_var); end
    tests_run++;
  endtask

  task automatic test_clear_drop();
    pattern3 = 3'b101;
    drive(0, 1, 0, 0);
    cycle();
    drive(0, 0, 1, 1); cycle();
    drive(0, 0, 1, 0); cycle();
    drive(0, 1, 1, 1); cycle();
    if (if_a.q !== 1'b0) begin failures++; $display("FAIL clrdrop_q_a got %0b exp 0", if_a.q); end
    tests_run++;
    if (if_a.state_var !== 2'd0) begin failures++; $display("FAIL clrdrop_state_a got %0d exp 0", if_a.state_var); end
    tests_run++;
    if (if_a.match_cnt !== 4'd0) begin failures++; $display("FAIL clrdrop_cnt_a got %0d exp 0", if_a.match_cnt); end
    tests_run++;
    drive(0, 0, 0, 0); cycle();
    if (if_a.q !== 1'b0) begin failures++; $display("FAIL clrdrop_after_q_a got %0b exp 0", if_a.q); end
    tests_run++;
  endtask

  task automatic test_random();
    int unsigned idx = 0;
    int unsigned r;
    pattern3 = 3'($urandom);
    pattern2 = 2'($urandom);
    pattern4 = 8'($urandom);
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      drive(r == 0, r == 1 || r == 2, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      // Bias the wide stream toward the pattern so non-overlap matches actually occur
      if ($urandom_range(0, 9) < 8) begin
        sym2 = pattern4[2*idx +: 2];
        idx  = (idx + 1) % 4;
      end
      cycle();
      if (if_a.q !== ea || if_a.match_cnt !== 4'(ca) || if_a.state_var !== 2'(ha.size()))
        begin failures++; $display("FAIL rnd_a cyc%0d got q%0b c%0d s%0d exp q%0b c%0d s%0d", k, if_a.q, if_a.match_cnt, if_a.state_var, ea, ca, ha.size()); end
      tests_run++;
      if (if_b.q !== eb || if_b.match_cnt !== 4'(cb) || if_b.state_var !== 2'(hb.size()))
        begin failures++; $display("FAIL rnd_b cyc%0d got q%0b c%0d s%0d exp q%0b c%0d s%0d", k, if_b.q, if_b.match_cnt, if_b.state_var, eb, cb, hb.size()); end
      tests_run++;
      if (if_c.q !== ec || if_c.match_cnt !== 2'(cc) || if_c.state_var !== 2'(hc.size()))
        begin failures++; $display("FAIL rnd_c cyc%0d got q%0b c%0d s%0d exp q%0b c%0d s%0d", k, if_c.q, if_c.match_cnt, if_c.state_var, ec, cc, hc.size()); end
      tests_run++;
      if (if_d.q !== ed || if_d.match_cnt !== 3'(cd) || if_d.state_var !== 3'(hd.size()))
        begin failures++; $display("FAIL rnd_d cyc%0d got q%0b c%0d s%0d exp q%0b c%0d s%0d", k, if_d.q, if_d.match_cnt, if_d.state_var, ed, cd, hd.size()); end
      tests_run++;
    end
  endtask

  initial begin
    pattern3 = 3'b101;
    pattern2 = 2'b11;
    pattern4 = 8'b00_11_01_10;
    drive(1, 0, 0, 0);
    test_reset();
    test_overlap_modes();
    test_valid_gap();
    test_reset_mid();
    test_back_to_back();
    test_clear_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
